uart_ans_turnaround_ctrl: RTL and testbench

Half-duplex turnaround controller on the transmit side of the UART core. It gates transmit launches so that a programmable guard gap, counted in 10MHz ticks, has elapsed since the last received byte. It drives the line-driver enable and, after each send, waits for the peer's answer, flagging a sticky timeout if none arrives. It sits between the host request logic and the tx core, sharing the 10MHz tick and the rx/tx done pulses with the answer-delay measurement path.

---
 rtl/uart_ans_pkg.sv | 20 ++
 rtl/uart_sat_tick_cnt.sv | 29 ++
 rtl/uart_ans_turnaround_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_ans_turnaround_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ans_pkg.sv
// Shared types and constants for the UART answer/turnaround controller.
// The optional tail-hold feature is enabled with UART_DRV_TAIL_EN.
package uart_ans_pkg;

  localparam int unsigned TICK_W = 16;

  localparam logic [TICK_W-1:0] GUARD_RST   = 16'd35;
  localparam logic [TICK_W-1:0] TIMEOUT_RST = 16'd9999;
  localparam logic [TICK_W-1:0] TAIL_RST    = 16'd10;
  localparam logic [TICK_W-1:0] CNT_SAT     = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_TX     = 3'd2,
    ST_TAIL   = 3'd3,
    ST_LISTEN = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sat_tick_cnt.sv
// 16-bit tick counter: synchronous clear, synchronous set-to-all-ones,
// enable, and optional saturation at all-ones.
module uart_sat_tick_cnt
  import uart_ans_pkg::*;
#(
  parameter logic [TICK_W-1:0] RST_VAL  = '0,
  parameter bit                SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set,
  input  logic              en,
  output logic [TICK_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= RST_VAL;
    end else if (clr) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= '1;
    end else if (en && !(SATURATE && (cnt == CNT_SAT))) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_ans_turnaround_ctrl.sv
// Half-duplex turnaround controller: guard gap before launch, driver enable,
// answer timeout. Define UART_DRV_TAIL_EN to hold the driver for a tail after send.
module uart_ans_turnaround_ctrl
  import uart_ans_pkg::*;
#(
  parameter logic [15:0] DEF_GUARD   = GUARD_RST,
  parameter logic [15:0] DEF_TIMEOUT = TIMEOUT_RST
`ifdef UART_DRV_TAIL_EN
  , parameter logic [15:0] TAIL_TICKS = TAIL_RST
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_sig_10MHz_i,
  input  logic        p_DataReceived_i,
  input  logic        p_SendFinished_i,
  input  logic        p_tx_req_i,
  output logic        p_tx_start_o,
  output logic        p_drv_en_o,
  output logic        p_busy_o,
  output logic        p_guard_ok_o,
  output logic        p_timeout_o,
  input  logic        n_wr_cfg_i,
  input  logic [15:0] cfg_guard_i,
  input  logic [15:0] cfg_timeout_i,
  input  logic        n_clr_i
);

  state_t            state, state_nxt;
  logic [TICK_W-1:0] guard_cfg_r, timeout_cfg_r;
  logic [TICK_W-1:0] gd_cnt, to_cnt;
  logic              to_hit, timeout_set;
  logic              gd_clr, gd_set, gd_en;
  logic              timeout_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_cfg_r   <= DEF_GUARD;
      timeout_cfg_r <= DEF_TIMEOUT;
    end else if (!n_wr_cfg_i) begin
      guard_cfg_r   <= cfg_guard_i;
      timeout_cfg_r <= cfg_timeout_i;
    end
  end

  assign p_guard_ok_o = (gd_cnt >= guard_cfg_r);
  assign to_hit       = (to_cnt >= timeout_cfg_r);

`ifdef UART_DRV_TAIL_EN
  logic [TICK_W-1:0] tail_cnt;
  logic              tail_done;

  assign tail_done = (tail_cnt >= TAIL_TICKS);

  uart_sat_tick_cnt #(.RST_VAL('0), .SATURATE(1'b1)) u_tail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_TAIL),
    .set (1'b0),
    .en  (p_sig_10MHz_i),
    .cnt (tail_cnt)
  );
`endif

  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!p_DataReceived_i && p_tx_req_i && p_guard_ok_o) begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nxt = ST_TX;
      ST_TX: begin
        if (p_SendFinished_i) begin
`ifdef UART_DRV_TAIL_EN
          state_nxt = ST_TAIL;
`else
          state_nxt = ST_LISTEN;
`endif
        end
      end
`ifdef UART_DRV_TAIL_EN
      ST_TAIL: begin
        if (tail_done) begin
          state_nxt = ST_LISTEN;
        end
      end
`endif
      ST_LISTEN: begin
        // An answer on the same cycle as the timeout suppresses the flag.
        if (p_DataReceived_i) begin
          state_nxt = ST_IDLE;
        end else if (to_hit) begin
          timeout_set = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign p_tx_start_o = (state == ST_LAUNCH);
  assign p_drv_en_o   = (state == ST_LAUNCH) || (state == ST_TX) || (state == ST_TAIL);
  assign p_busy_o     = (state != ST_IDLE);

  // Guard counter only runs in IDLE; a timeout marks the line quiet again.
  assign gd_clr = p_DataReceived_i && ((state == ST_IDLE) || (state == ST_LISTEN));
  assign gd_set = timeout_set;
  assign gd_en  = (state == ST_IDLE) && p_sig_10MHz_i;

  uart_sat_tick_cnt #(.RST_VAL(CNT_SAT), .SATURATE(1'b1)) u_gd_cnt (
    .clk (clk),
    .rst (rst),
    .clr (gd_clr),
    .set (gd_set),
    .en  (gd_en),
    .cnt (gd_cnt)
  );

  uart_sat_tick_cnt #(.RST_VAL('0), .SATURATE(1'b1)) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_LISTEN),
    .set (1'b0),
    .en  (p_sig_10MHz_i),
    .cnt (to_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_r <= 1'b0;
    end else if (timeout_set) begin
      timeout_r <= 1'b1;
    end else if (!n_clr_i) begin
      timeout_r <= 1'b0;
    end
  end

  assign p_timeout_o = timeout_r;

endmodule

// File: tb/tb_uart_ans_turnaround_ctrl.sv
// Self-checking bench for uart_ans_turnaround_ctrl with random tick stimulus.
// Expected timing is derived from tick counts kept by the bench.
module tb_uart_ans_turnaround_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        rx = 1'b0;
  logic        send_fin = 1'b0;
  logic        req = 1'b0;
  logic        start, drv_en, busy, guard_ok, timeout;
  logic        n_wr = 1'b1;
  logic [15:0] cfg_guard = '0;
  logic [15:0] cfg_timeout = '0;
  logic        n_clr = 1'b1;

  int          checks = 0;
  int          passed = 0;
  logic        edge_tick = 1'b0;
  logic [15:0] cur_guard = 16'd35;
  logic [15:0] cur_timeout = 16'd9999;

  uart_ans_turnaround_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .p_sig_10MHz_i    (tick),
    .p_DataReceived_i (rx),
    .p_SendFinished_i (send_fin),
    .p_tx_req_i       (req),
    .p_tx_start_o     (start),
    .p_drv_en_o       (drv_en),
    .p_busy_o         (busy),
    .p_guard_ok_o     (guard_ok),
    .p_timeout_o      (timeout),
    .n_wr_cfg_i       (n_wr),
    .cfg_guard_i      (cfg_guard),
    .cfg_timeout_i    (cfg_timeout),
    .n_clr_i          (n_clr)
  );

  always #5 clk = ~clk;

  // Advance one clock; edge_tick records the tick level seen by that edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_tick = tick;
    tick = ($urandom_range(0, 3) == 0);
  endtask

  task automatic cfg_write(input logic [15:0] g, input logic [15:0] t);
    cfg_guard = g;
    cfg_timeout = t;
    n_wr = 1'b0;
    step();
    n_wr = 1'b1;
    cur_guard = g;
    cur_timeout = t;
  endtask

  // From the LAUNCH cycle: stay in TX a while, finish, then answer.
  task automatic finish_send();
    int unsigned n;
    n = $urandom_range(1, 4);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      checks++;
      if ({drv_en, busy, start} !== 3'b110)
        $display("FAIL tx_hold: {drv,busy,start}=%b required 110", {drv_en, busy, start});
      else passed++;
    end
    send_fin = 1'b1;
    step();
    send_fin = 1'b0;
`ifndef UART_DRV_TAIL_EN
    checks++;
    if ({drv_en, busy} !== 2'b01)
      $display("FAIL drv_drop: {drv,busy}=%b required 01", {drv_en, busy});
    else passed++;
`endif
    for (int i = 0; i < 400; i++) begin
      if (!drv_en) break;
      step();
    end
    checks++;
    if (drv_en !== 1'b0) $display("FAIL drv_release: drv=%b required 0", drv_en);
    else passed++;
    rx = 1'b1;
    step();
    rx = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL answer_idle: busy=%b required 0", busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({start, drv_en, busy, guard_ok, timeout} !== 5'b00010)
      $display("FAIL reset_async: {start,drv,busy,gok,to}=%b required 00010",
               {start, drv_en, busy, guard_ok, timeout});
    else passed++;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    step();
    checks++;
    if ({start, drv_en, busy, guard_ok, timeout} !== 5'b00010)
      $display("FAIL reset_release: {start,drv,busy,gok,to}=%b required 00010",
               {start, drv_en, busy, guard_ok, timeout});
    else passed++;
    cur_guard = 16'd35;
    cur_timeout = 16'd9999;
  endtask

  task automatic test_basic();
    req = 1'b1;
    step();
    req = 1'b0;
    checks++;
    if ({start, drv_en, busy} !== 3'b111)
      $display("FAIL launch_latency: {start,drv,busy}=%b required 111", {start, drv_en, busy});
    else passed++;
    send_fin = 1'b1;      // ignored while launching
    step();
    send_fin = 1'b0;
    checks++;
    if ({start, drv_en, busy} !== 3'b011)
      $display("FAIL launch_ignores_fin: {start,drv,busy}=%b required 011", {start, drv_en, busy});
    else passed++;
    rx = 1'b1;            // own echo ignored in TX
    step();
    rx = 1'b0;
    checks++;
    if ({drv_en, busy} !== 2'b11)
      $display("FAIL tx_ignores_echo: {drv,busy}=%b required 11", {drv_en, busy});
    else passed++;
    finish_send();
  endtask

  task automatic test_guard(input logic [15:0] g, input bit write);
    int   count;
    bit   ok_before;
    bit   launched;
    if (write) cfg_write(g, cur_timeout);
    rx = 1'b1;
    step();
    rx = 1'b0;
    count = 0;
    launched = 1'b0;
    req = 1'b1;
    checks++;
    if (guard_ok !== (count >= int'(cur_guard)))
      $display("FAIL guard_after_rx: gok=%b required %b", guard_ok, (count >= int'(cur_guard)));
    else passed++;
    for (int i = 0; i < 3000; i++) begin
      ok_before = (count >= int'(cur_guard));
      step();
      checks++;
      if (start !== ok_before) begin
        $display("FAIL guard_start g=%0d ticks=%0d: start=%b required %b",
                 cur_guard, count, start, ok_before);
        break;
      end else passed++;
      if (ok_before) begin
        launched = 1'b1;
        break;
      end
      if (edge_tick) count++;
    end
    req = 1'b0;
    checks++;
    if (!launched) $display("FAIL guard_launch_timeout: start never seen, required 1");
    else passed++;
    if (launched) finish_send();
  endtask

  task automatic test_same_cycle();
    cfg_write(16'd5, cur_timeout);
    for (int i = 0; i < 500; i++) begin
      if (guard_ok) break;
      step();
    end
    checks++;
    if (guard_ok !== 1'b1) $display("FAIL same_pre_guard: gok=%b required 1", guard_ok);
    else passed++;
    rx = 1'b1;
    req = 1'b1;
    step();
    rx = 1'b0;
    req = 1'b0;
    checks++;
    if ({start, busy, guard_ok} !== 3'b000)
      $display("FAIL same_cycle_g5: {start,busy,gok}=%b required 000", {start, busy, guard_ok});
    else passed++;
    cfg_write(16'd0, cur_timeout);
    rx = 1'b1;
    req = 1'b1;
    step();
    rx = 1'b0;
    checks++;
    if ({start, guard_ok} !== 2'b01)
      $display("FAIL same_cycle_g0: {start,gok}=%b required 01", {start, guard_ok});
    else passed++;
    step();
    req = 1'b0;
    checks++;
    if (start !== 1'b1) $display("FAIL guard0_launch: start=%b required 1", start);
    else passed++;
    finish_send();
  endtask

  task automatic test_timeout(input int t, input int answer_at, input bit hold_clr);
    int count;
    bit reached;
    bit answered;
    bit done;
    cfg_write(16'd0, 16'(t));
    req = 1'b1;
    step();
    req = 1'b0;
    checks++;
    if (start !== 1'b1) $display("FAIL to_launch: start=%b required 1", start);
    else passed++;
    step();
    send_fin = 1'b1;
    step();
    send_fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!drv_en) break;
      step();
    end
    checks++;
    if ({drv_en, busy} !== 2'b01)
      $display("FAIL to_listen: {drv,busy}=%b required 01", {drv_en, busy});
    else passed++;
    n_clr = !hold_clr;
    count = 0;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reached = (count >= t);
      answered = (answer_at >= 0) && (count == answer_at);
      rx = answered;
      step();
      rx = 1'b0;
      if (answered) begin
        checks++;
        if ({busy, timeout} !== 2'b00)
          $display("FAIL to_answer t=%0d at=%0d: {busy,to}=%b required 00", t, count, {busy, timeout});
        else passed++;
        done = 1'b1;
        break;
      end else if (reached) begin
        checks++;
        if ({busy, timeout} !== 2'b01)
          $display("FAIL to_fire t=%0d: {busy,to}=%b required 01", t, {busy, timeout});
        else passed++;
        done = 1'b1;
        break;
      end else begin
        checks++;
        if ({busy, timeout} !== 2'b10) begin
          $display("FAIL to_wait t=%0d ticks=%0d: {busy,to}=%b required 10", t, count, {busy, timeout});
          break;
        end else passed++;
      end
      if (edge_tick) count++;
    end
    checks++;
    if (!done) $display("FAIL to_bound t=%0d: listen never ended, required end", t);
    else passed++;
    if (hold_clr) begin
      step();
      n_clr = 1'b1;
      checks++;
      if (timeout !== 1'b0) $display("FAIL to_held_clr: to=%b required 0", timeout);
      else passed++;
    end else if (!answered) begin
      cfg_write(16'hFFFF, 16'(t));
      checks++;
      if (guard_ok !== 1'b1) $display("FAIL to_line_quiet: gok=%b required 1", guard_ok);
      else passed++;
      n_clr = 1'b0;
      step();
      n_clr = 1'b1;
      checks++;
      if (timeout !== 1'b0) $display("FAIL to_clear: to=%b required 0", timeout);
      else passed++;
    end
    repeat (20) step();
    checks++;
    if ({busy, timeout} !== 2'b00)
      $display("FAIL to_settled: {busy,to}=%b required 00", {busy, timeout});
    else passed++;
  endtask

`ifdef UART_DRV_TAIL_EN
  task automatic test_tail();
    int count;
    bit reached;
    cfg_write(16'd0, 16'd9999);
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    send_fin = 1'b1;
    step();
    send_fin = 1'b0;
    count = 0;
    for (int i = 0; i < 2000; i++) begin
      reached = (count >= 10);
      rx = ($urandom_range(0, 2) == 0);
      step();
      rx = 1'b0;
      checks++;
      if ({drv_en, busy} !== {!reached, 1'b1}) begin
        $display("FAIL tail ticks=%0d: {drv,busy}=%b required %b", count, {drv_en, busy}, {!reached, 1'b1});
        break;
      end else passed++;
      if (reached) break;
      if (edge_tick) count++;
    end
    rx = 1'b1;
    step();
    rx = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL tail_answer: busy=%b required 0", busy);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_send();
    cfg_write(16'd0, 16'd50);
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    checks++;
    if ({drv_en, busy} !== 2'b11)
      $display("FAIL mid_pre: {drv,busy}=%b required 11", {drv_en, busy});
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({start, drv_en, busy, guard_ok, timeout} !== 5'b00010)
      $display("FAIL mid_async: {start,drv,busy,gok,to}=%b required 00010",
               {start, drv_en, busy, guard_ok, timeout});
    else passed++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    step();
    checks++;
    if ({busy, guard_ok, timeout} !== 3'b010)
      $display("FAIL mid_release: {busy,gok,to}=%b required 010", {busy, guard_ok, timeout});
    else passed++;
    cur_guard = 16'd35;
    cur_timeout = 16'd9999;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_guard(16'd35, 1'b0);
    test_guard(16'($urandom_range(1, 40)), 1'b1);
    test_guard(16'd0, 1'b1);
    test_same_cycle();
    test_timeout(100, -1, 1'b0);
    test_timeout(100, 50, 1'b0);
    test_timeout(0, -1, 1'b0);
    test_timeout(30, 30, 1'b0);
    test_timeout(int'($urandom_range(1, 40)), -1, 1'b1);
    test_timeout(int'($urandom_range(5, 60)), int'($urandom_range(0, 4)), 1'b0);
`ifdef UART_DRV_TAIL_EN
    test_tail();
`endif
    test_reset_mid_send();
    test_guard(16'd35, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
